// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types for the pipeline hazard controller
package pipeline_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MD_BUSY  = 2'b01,
    MEM_WAIT = 2'b10
  } ctrl_state_t;

endpackage

// File: rtl/muldiv_timer.sv
// rtl/muldiv_timer.sv - mult/div occupancy down-counter with freeze
module muldiv_timer #(
  parameter int MULDIV_LATENCY = 32,
  parameter int CNT_W          = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic decrement,
  input  logic freeze,
  output logic done
);

  logic [CNT_W-1:0] count;

  // The start cycle in RUN is the first occupancy cycle, hence LATENCY-2.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!freeze) begin
      if (load)
        count <= CNT_W'(MULDIV_LATENCY - 2);
      else if (decrement && count != '0)
        count <= count - CNT_W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - 5-stage hazard/stall/flush/forward controller (option: PIPELINE_FWD_EN)
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int MULDIV_LATENCY = 32,
  parameter int CNT_W          = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] d_rs,
  input  logic [REG_ADDR_W-1:0] d_rt,
  input  logic [REG_ADDR_W-1:0] e_rs,
  input  logic [REG_ADDR_W-1:0] e_rt,
  input  logic [REG_ADDR_W-1:0] e_wa,
  input  logic                  e_rf_we,
  input  logic                  e_is_load,
  input  logic                  e_md_start,
  input  logic [REG_ADDR_W-1:0] m_wa,
  input  logic                  m_rf_we,
  input  logic                  m_branch_taken,
  input  logic                  m_dmem_req,
  input  logic                  dmem_ready,
  input  logic [REG_ADDR_W-1:0] w_wa,
  input  logic                  w_rf_we,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  stall_m,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  flush_m,
  output logic                  flush_w,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  md_busy
);

  ctrl_state_t state, ret_state, eff_state;
  logic        freeze, md_done, md_load, md_dec, md_stall, hazard;
  fwd_sel_t    fwd_a_sel, fwd_b_sel;

  function automatic logic hit(input logic we, input logic [REG_ADDR_W-1:0] wa,
                               input logic [REG_ADDR_W-1:0] src);
    return we && (wa != '0) && (wa == src);
  endfunction

  // While frozen, behave as the remembered state once the memory answers.
  assign freeze    = m_dmem_req && !dmem_ready;
  assign eff_state = (state == MEM_WAIT) ? ret_state : state;
  assign md_load   = (eff_state == RUN) && e_md_start;
  assign md_dec    = (eff_state == MD_BUSY);
  assign md_stall  = md_load || (md_dec && !md_done);

`ifdef PIPELINE_FWD_EN
  assign hazard = e_is_load && (hit(e_rf_we, e_wa, d_rs) || hit(e_rf_we, e_wa, d_rt));
  assign fwd_a_sel = hit(m_rf_we, m_wa, e_rs) ? FWD_M :
                     hit(w_rf_we, w_wa, e_rs) ? FWD_W : FWD_RF;
  assign fwd_b_sel = hit(m_rf_we, m_wa, e_rt) ? FWD_M :
                     hit(w_rf_we, w_wa, e_rt) ? FWD_W : FWD_RF;
`else
  // Without bypassing, hold D until every producer has reached W.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{e_is_load, e_rs, e_rt, w_wa, w_rf_we};
  assign hazard = hit(e_rf_we, e_wa, d_rs) || hit(e_rf_we, e_wa, d_rt) ||
                  hit(m_rf_we, m_wa, d_rs) || hit(m_rf_we, m_wa, d_rt);
  assign fwd_a_sel = FWD_RF;
  assign fwd_b_sel = FWD_RF;
`endif

  muldiv_timer #(
    .MULDIV_LATENCY(MULDIV_LATENCY),
    .CNT_W         (CNT_W)
  ) u_muldiv_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (md_load),
    .decrement(md_dec),
    .freeze   (freeze),
    .done     (md_done)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      ret_state <= RUN;
    end else if (freeze) begin
      state     <= MEM_WAIT;
      ret_state <= eff_state;
    end else begin
      case (eff_state)
        RUN:     state <= e_md_start ? MD_BUSY : RUN;
        MD_BUSY: state <= md_done ? RUN : MD_BUSY;
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    flush_w = 1'b0;
    if (!reset) begin
      if (freeze) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (m_branch_taken) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
        flush_m = 1'b1;
      end else if (md_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
      end else if (hazard) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  assign md_busy = !reset && md_stall;
  assign fwd_a   = reset ? 2'b00 : fwd_a_sel;
  assign fwd_b   = reset ? 2'b00 : fwd_b_sel;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl (MULDIV_LATENCY=4)
module tb_pipeline_ctrl;

  localparam int AW = 5;
`ifdef PIPELINE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Output vector layout: stall_f,d,e,m flush_d,e,m,w fwd_a fwd_b md_busy
  localparam logic [12:0] SF = 13'h1000, SD = 13'h0800, SE = 13'h0400, SM = 13'h0200;
  localparam logic [12:0] FD = 13'h0100, FE = 13'h0080, FM = 13'h0040, FW = 13'h0020;
  localparam logic [12:0] MB = 13'h0001, E_NONE = 13'h0000;
  localparam logic [12:0] E_HAZ = SF | SD | FE;
  localparam logic [12:0] E_MD  = SF | SD | SE | FM | MB;
  localparam logic [12:0] E_FRZ = SF | SD | SE | SM | FW;
  localparam logic [12:0] E_BR  = FD | FE | FM;

  logic clock = 1'b0, reset = 1'b1;
  logic [AW-1:0] d_rs, d_rt, e_rs, e_rt, e_wa, m_wa, w_wa;
  logic e_rf_we, e_is_load, e_md_start, m_rf_we, m_branch_taken, m_dmem_req, dmem_ready, w_rf_we;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w, md_busy;
  logic [1:0] fwd_a, fwd_b;
  logic [12:0] obs, want;
  logic [12:0] exp_q[$];
  int checks = 0, failures = 0;

  assign obs = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
                fwd_a, fwd_b, md_busy};

  pipeline_ctrl #(.REG_ADDR_W(AW), .MULDIV_LATENCY(4), .CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .e_rs(e_rs), .e_rt(e_rt), .e_wa(e_wa),
    .e_rf_we(e_rf_we), .e_is_load(e_is_load), .e_md_start(e_md_start),
    .m_wa(m_wa), .m_rf_we(m_rf_we), .m_branch_taken(m_branch_taken),
    .m_dmem_req(m_dmem_req), .dmem_ready(dmem_ready),
    .w_wa(w_wa), .w_rf_we(w_rf_we),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .md_busy(md_busy)
  );

  always #5 clock = ~clock;

  function automatic logic [12:0] fx(input logic [1:0] a, input logic [1:0] b);
    return FWD ? {8'b0, a, b, 1'b0} : E_NONE;
  endfunction

  task automatic idle();
    d_rs = '0; d_rt = '0; e_rs = '0; e_rt = '0; e_wa = '0; m_wa = '0; w_wa = '0;
    e_rf_we = 0; e_is_load = 0; e_md_start = 0; m_rf_we = 0; m_branch_taken = 0;
    m_dmem_req = 0; dmem_ready = 1; w_rf_we = 0;
  endtask

  task automatic test_reset();
    idle();
    e_is_load = 1; e_rf_we = 1; e_wa = 5; d_rt = 5; m_branch_taken = 1;
    exp_q.push_back(E_NONE);
    #1 want = exp_q.pop_front(); checks++;
    if (obs !== want) begin failures++; $display("FAIL reset_hold got=%h want=%h", obs, want); end
    @(negedge clock); idle(); reset = 0;
    exp_q.push_back(E_NONE);
    #1 want = exp_q.pop_front(); checks++;
    if (obs !== want) begin failures++; $display("FAIL reset_release got=%h want=%h", obs, want); end
  endtask

  task automatic test_forwarding();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); idle();
      case (i)
        0: begin m_rf_we = 1; m_wa = 8; w_rf_we = 1; w_wa = 8; e_rs = 8; e_rt = 9; exp_q.push_back(fx(2'b10, 2'b00)); end
        1: begin m_rf_we = 1; m_wa = 0; w_rf_we = 1; w_wa = 8; e_rs = 0; e_rt = 9; exp_q.push_back(fx(2'b00, 2'b00)); end
        2: begin m_rf_we = 1; m_wa = 3; w_rf_we = 1; w_wa = 8; e_rs = 8; e_rt = 3; exp_q.push_back(fx(2'b01, 2'b10)); end
        default: begin m_rf_we = 0; m_wa = 3; w_rf_we = 1; w_wa = 8; e_rs = 8; e_rt = 3; exp_q.push_back(fx(2'b01, 2'b00)); end
      endcase
      #1 want = exp_q.pop_front(); checks++;
      if (obs !== want) begin failures++; $display("FAIL fwd step%0d got=%h want=%h", i, obs, want); end
    end
  endtask

  task automatic test_load_use();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); idle();
      case (i)
        0: begin e_is_load = 1; e_rf_we = 1; e_wa = 5; d_rt = 5; exp_q.push_back(E_HAZ); end
        1: begin m_rf_we = 1; m_wa = 5; d_rt = 5; exp_q.push_back(FWD ? E_NONE : E_HAZ); end
        default: begin m_rf_we = 1; m_wa = 5; e_rt = 5; exp_q.push_back(fx(2'b00, 2'b10)); end
      endcase
      #1 want = exp_q.pop_front(); checks++;
      if (obs !== want) begin failures++; $display("FAIL load_use step%0d got=%h want=%h", i, obs, want); end
    end
  endtask

  task automatic test_raw();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); idle();
      case (i)
        0: begin e_rf_we = 1; e_wa = 7; d_rs = 7; exp_q.push_back(FWD ? E_NONE : E_HAZ); end
        1: begin e_rf_we = 1; e_wa = 0; d_rs = 0; m_rf_we = 1; m_wa = 0; exp_q.push_back(E_NONE); end
        default: begin w_rf_we = 1; w_wa = 7; d_rs = 7; exp_q.push_back(E_NONE); end
      endcase
      #1 want = exp_q.pop_front(); checks++;
      if (obs !== want) begin failures++; $display("FAIL raw step%0d got=%h want=%h", i, obs, want); end
    end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); idle();
      if (i == 0) begin e_is_load = 1; e_rf_we = 1; e_wa = 5; d_rt = 5; end
      m_branch_taken = (i < 2);
      exp_q.push_back((i < 2) ? E_BR : E_NONE);
      #1 want = exp_q.pop_front(); checks++;
      if (obs !== want) begin failures++; $display("FAIL branch step%0d got=%h want=%h", i, obs, want); end
    end
  endtask

  task automatic test_muldiv();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); idle();
      e_md_start = (i < 4);
      exp_q.push_back((i < 3) ? E_MD : E_NONE);
      #1 want = exp_q.pop_front(); checks++;
      if (obs !== want) begin failures++; $display("FAIL muldiv cyc%0d got=%h want=%h", i, obs, want); end
    end
  endtask

  task automatic test_mem_wait();
    // Frozen load-use from RUN: freeze wins, no md occupancy.
    @(negedge clock); idle();
    e_is_load = 1; e_rf_we = 1; e_wa = 5; d_rt = 5; m_dmem_req = 1; dmem_ready = 0;
    exp_q.push_back(E_FRZ);
    #1 want = exp_q.pop_front(); checks++;
    if (obs !== want) begin failures++; $display("FAIL mem_run got=%h want=%h", obs, want); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clock); idle();
      e_md_start = (i < 7);
      if (i >= 2 && i <= 5) begin m_dmem_req = 1; m_branch_taken = 1; dmem_ready = (i == 5); end
      if (i < 2) exp_q.push_back(E_MD);
      else if (i < 5) exp_q.push_back(E_FRZ | MB);
      else if (i == 5) exp_q.push_back(E_BR | MB);
      else exp_q.push_back(E_NONE);
      #1 want = exp_q.pop_front(); checks++;
      if (obs !== want) begin failures++; $display("FAIL mem_md cyc%0d got=%h want=%h", i, obs, want); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); idle(); e_md_start = 1;
      exp_q.push_back(E_MD);
      #1 want = exp_q.pop_front(); checks++;
      if (obs !== want) begin failures++; $display("FAIL rst_mid pre%0d got=%h want=%h", i, obs, want); end
    end
    #2 reset = 1; e_is_load = 1; e_rf_we = 1; e_wa = 5; d_rt = 5; m_rf_we = 1; m_wa = 3; e_rs = 3;
    exp_q.push_back(E_NONE);
    #1 want = exp_q.pop_front(); checks++;
    if (obs !== want) begin failures++; $display("FAIL rst_mid async got=%h want=%h", obs, want); end
    @(negedge clock); idle(); reset = 0;
    exp_q.push_back(E_NONE);
    #1 want = exp_q.pop_front(); checks++;
    if (obs !== want) begin failures++; $display("FAIL rst_mid idle got=%h want=%h", obs, want); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); idle();
      e_md_start = (i < 4);
      exp_q.push_back((i < 3) ? E_MD : E_NONE);
      #1 want = exp_q.pop_front(); checks++;
      if (obs !== want) begin failures++; $display("FAIL rst_mid restart%0d got=%h want=%h", i, obs, want); end
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_raw();
    test_branch();
    test_muldiv();
    test_mem_wait();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Hazard and sequencing controller for the 5-stage pipeline: fetch_reg, decode_reg, execute_reg, memory_reg, writeback_reg.
- Generates per-stage stall (hold) and flush (bubble) strobes.
- Generates ALU operand forwarding selects.
- Sequences multi-cycle mult/div occupancy and data-memory wait states.
- Single instance in the datapath top; pipeline registers gain an enable driven by ~stall_x.

Parameters:
REG_ADDR_W, 5, register-file address width.
MULDIV_LATENCY, 32, total cycles a mult/div occupies E (legal range 2..255).
CNT_W, 8, width of mult/div down-counter.

Ports:
clock  in  1  clock.
reset  in  1  reset, asynchronous, active-high.
d_rs  in  REG_ADDR_W  source reg A of instruction in D.
d_rt  in  REG_ADDR_W  source reg B of instruction in D.
e_rs  in  REG_ADDR_W  source reg A of instruction in E.
e_rt  in  REG_ADDR_W  source reg B of instruction in E.
e_wa  in  REG_ADDR_W  dest reg of instruction in E.
e_rf_we  in  1  E instruction writes RF.
e_is_load  in  1  E instruction is a load (sel_result = memory).
e_md_start  in  1  E instruction is mult/div (level, valid while in E).
m_wa  in  REG_ADDR_W  dest reg in M.
m_rf_we  in  1  M writes RF.
m_branch_taken  in  1  branch/jump resolved taken in M (m_sel_pc).
m_dmem_req  in  1  M stage accesses data memory.
dmem_ready  in  1  data memory completes access this cycle.
w_wa  in  REG_ADDR_W  dest reg in W.
w_rf_we  in  1  W writes RF.
stall_f, stall_d, stall_e, stall_m  out  1 each  hold fetch/decode/execute/memory register.
flush_d, flush_e, flush_m, flush_w  out  1 each  clear decode/execute/memory/writeback register.
fwd_a, fwd_b  out  2  ALU operand select: 00 register file, 01 from W, 10 from M.
md_busy  out  1  mult/div occupying E.

Behaviour:
- Reset: state RUN, counter 0. While reset is high, all stall_*, flush_*, fwd_*, md_busy = 0.
- States (registered): RUN, MD_BUSY, MEM_WAIT. All strobe outputs are combinational from state + inputs, taking effect in the same cycle.
- Register 0 never matches in any comparison.
- Forwarding, fwd_a (fwd_b identical using e_rt):
  - 10 if m_rf_we && m_wa==e_rs.
  - else 01 if w_rf_we && w_wa==e_rs.
  - else 00.
  - M has priority over W.
- Load-use: e_is_load && e_rf_we && (e_wa==d_rs || e_wa==d_rt) → stall_f=stall_d=1, flush_e=1 for exactly 1 cycle.
- Branch: m_branch_taken → flush_d=flush_e=flush_m=1; stalls suppressed. Overrides load-use when both occur in the same cycle.
- Mult/div:
  - In RUN with e_md_start=1: enter MD_BUSY, counter ← MULDIV_LATENCY-2.
  - In MD_BUSY: md_busy=1, stall_f=stall_d=stall_e=1, flush_m=1; counter decrements each cycle.
  - At counter==0, return to RUN with stalls released. The next edge advances the mult/div out of E.
  - Total E occupancy = MULDIV_LATENCY cycles. e_md_start is ignored in MD_BUSY.
- Memory wait:
  - m_dmem_req && !dmem_ready (any state) → MEM_WAIT. All stall_f/d/e/m = 1, flush_w=1; all other flushes = 0.
  - Highest priority: a branch flush is deferred while frozen (m_branch_taken stays asserted and fires on the ready cycle).
  - The MD counter freezes during MEM_WAIT and the return state is remembered (RUN or MD_BUSY).
  - When dmem_ready=1, the same cycle is treated as normal: MEM_WAIT exit and the pending branch flush both occur that cycle.
- Priority order: MEM_WAIT freeze > branch flush > MD_BUSY stall > load-use stall.
- Reset mid-operation: the state machine aborts to RUN immediately (async).

Optional Feature:
PIPELINE_FWD_EN:
- Defined: forwarding as above.
- Undefined:
  - fwd_a=fwd_b=00 constant.
  - Any RAW dependency of D sources on E or M destination (rf_we=1, nonzero) → stall_f=stall_d=1, flush_e=1 until the producer reaches W.
  - The RF write-before-read covers W.
  - Load-use logic is subsumed by this rule.

Decomposition:
- pipeline_pkg additions:
  - fwd_sel_t enum (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10).
  - ctrl_state_t enum (RUN, MD_BUSY, MEM_WAIT).
- Sub-module muldiv_timer: load/decrement/freeze/done counter, parameterised by MULDIV_LATENCY and CNT_W.

Test Plan:
- Forwarding: m_rf_we=1, m_wa=8, w_rf_we=1, w_wa=8, e_rs=8, e_rt=9 → fwd_a=10, fwd_b=00. Repeat with e_rs=0 and m_wa=0 → fwd_a=00.
- Load-use: e_is_load=1, e_wa=5, d_rt=5 → 1 cycle with stall_f=stall_d=flush_e=1; next cycle (load in M) all strobes 0, fwd_b=10 when the consumer is in E.
- Branch + load-use: same cycle m_branch_taken=1 → flush_d=flush_e=flush_m=1, stall_f=stall_d=0.
- Mult/div, MULDIV_LATENCY=4: e_md_start pulse → md_busy=1 and stalls for 3 cycles, then release; the instruction leaves E after 4 edges; flush_m=1 during busy.
- Mem wait: m_dmem_req=1, dmem_ready=0 for 3 cycles during MD_BUSY plus m_branch_taken=1 → all stalls and flush_w=1 for 3 cycles, MD counter frozen; on ready, branch flushes fire and the MD count resumes.
- Reset in MD_BUSY (async mid-cycle) → all outputs 0 immediately; after release, state RUN and no stall.
